// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the CPU control path.
//   INSTR_W           instruction word width
//   OPC_*/OPD_*       opcode and operand field positions inside an instruction
//   OP_*              opcode constants
//   seqState_t        instruction sequencer state encoding
// Optional macro SEQ_SINGLE_STEP_EN adds the S_STEP state.
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_HI  = 7;
  localparam int OPC_LO  = 4;
  localparam int OPD_HI  = 3;
  localparam int OPD_LO  = 0;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_IN  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_NOP = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_EXEC,
`ifdef SEQ_SINGLE_STEP_EN
    S_HALT,
    S_STEP
`else
    S_HALT
`endif
  } seqState_t;

endpackage

// File: rtl/pc_counter.sv
// pc_counter -- program counter with load, increment and hold.
//   clk      system clock
//   rstN     asynchronous active-low clear
//   load     load loadVal (has priority over inc)
//   inc      increment, wrapping modulo 2^PC_W
//   loadVal  jump target
//   pc       current program counter
module pc_counter #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] loadVal,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc <= '0;
    end else if (load) begin
      pc <= loadVal;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer -- fetches instructions from a synchronous program ROM and
// issues opcode/operand to the control unit one instruction at a time.
// Resolves JMP and HLT locally; hold stretches the EXEC cycle.
//   clk       system clock
//   rstN      asynchronous active-low reset
//   run       level, start/continue execution
//   hold      stretch EXEC (sampled only in EXEC)
//   step      single-step advance (only with SEQ_SINGLE_STEP_EN)
//   progAddr  ROM address (the PC)
//   progData  ROM data, valid one cycle after progAddr
//   opCode    opcode to control unit (OP_NOP outside ISSUE/EXEC)
//   operand   immediate / jump target (0 outside ISSUE/EXEC)
//   opValid   one-cycle pulse in ISSUE
//   busy      high in FETCH, DECODE, ISSUE, EXEC
//   halted    high in HALT
//   pcOut     current PC for debug
// Optional macro SEQ_SINGLE_STEP_EN: adds the step port and the STEP state.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for run
// S_FETCH  | progAddr = pc, ROM read in flight
// S_DECODE | progData captured into the instruction register
// S_ISSUE  | opCode/operand presented, opValid pulse
// S_EXEC   | control unit executes; PC updated when hold is low
// S_HALT   | HLT reached, PC frozen on the HLT address until run drops
// S_STEP   | (single-step build) waiting for a step pulse
module instr_sequencer #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               run,
  input  logic               hold,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic [PC_W-1:0]    progAddr,
  input  logic [INSTR_W-1:0] progData,
  output logic [3:0]         opCode,
  output logic [3:0]         operand,
  output logic               opValid,
  output logic               busy,
  output logic               halted,
  output logic [PC_W-1:0]    pcOut
);
  import cpu_pkg::*;

  seqState_t          state;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    jumpTarget;
  logic               isJump;
  logic               execDone;
  logic               pcLoad;
  logic               pcInc;

  assign isJump     = (ir[OPC_HI:OPC_LO] == OP_JMP);
  assign execDone   = (state == S_EXEC) && !hold;
  // Size cast zero-extends or truncates the 4-bit operand to PC_W.
  assign jumpTarget = PC_W'(ir[OPD_HI:OPD_LO]);
  assign pcLoad     = execDone && isJump;
  // Leaving HALT advances past the HLT so a later run restarts after it.
  assign pcInc      = (execDone && !isJump) || ((state == S_HALT) && !run);

  pc_counter #(.PC_W(PC_W)) uPc (
    .clk     (clk),
    .rstN    (rstN),
    .load    (pcLoad),
    .inc     (pcInc),
    .loadVal (jumpTarget),
    .pc      (pc)
  );

  // The PC is stable from FETCH through DECODE, so it serves directly as the
  // ROM address and the read data lines up with DECODE.
  assign progAddr = pc;
  assign pcOut    = pc;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= S_IDLE;
      ir      <= '0;
      opCode  <= OP_NOP;
      operand <= '0;
      opValid <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      opValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir      <= progData;
          opCode  <= progData[OPC_HI:OPC_LO];
          operand <= progData[OPD_HI:OPD_LO];
          opValid <= 1'b1;
          state   <= S_ISSUE;
        end
        S_ISSUE: begin
          if (ir[OPC_HI:OPC_LO] == OP_HLT) begin
            state   <= S_HALT;
            busy    <= 1'b0;
            halted  <= 1'b1;
            opCode  <= OP_NOP;
            operand <= '0;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!hold) begin
            opCode  <= OP_NOP;
            operand <= '0;
`ifdef SEQ_SINGLE_STEP_EN
            state   <= S_STEP;
            busy    <= 1'b0;
`else
            if (run) begin
              state <= S_FETCH;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
`endif
          end
        end
        S_HALT: begin
          if (!run) begin
            state  <= S_IDLE;
            halted <= 1'b0;
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_STEP: begin
          if (step) begin
            if (run) begin
              state <= S_FETCH;
              busy  <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       run, hold;
  logic [3:0] progAddr, pcOut, opCode, operand;
  logic [7:0] progData;
  logic       opValid, busy, halted;

  logic       run2;
  logic [1:0] progAddr2, pcOut2;
  logic [7:0] progData2;
  logic [3:0] opCode2, operand2;
  logic       opValid2, busy2, halted2;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step;
`endif

  logic [7:0] rom [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) progData <= rom[progAddr];
  assign progData2 = 8'h00;

  instr_sequencer #(.PC_W(4), .INSTR_W(8)) dut (
    .clk(clk), .rstN(rstN), .run(run), .hold(hold),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .progAddr(progAddr), .progData(progData), .opCode(opCode), .operand(operand),
    .opValid(opValid), .busy(busy), .halted(halted), .pcOut(pcOut)
  );

  instr_sequencer #(.PC_W(2), .INSTR_W(8)) dut2 (
    .clk(clk), .rstN(rstN), .run(run2), .hold(1'b0),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .progAddr(progAddr2), .progData(progData2), .opCode(opCode2), .operand(operand2),
    .opValid(opValid2), .busy(busy2), .halted(halted2), .pcOut(pcOut2)
  );

  typedef struct {
    logic       run;
    logic       hold;
    logic       opValid;
    logic [3:0] opCode;
    logic [3:0] operand;
    logic       busy;
    logic       halted;
    logic [3:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic h, input logic v, input logic [3:0] oc,
                              input logic [3:0] od, input logic b, input logic hl, input logic [3:0] p);
    vec_t t;
    t.run = r; t.hold = h; t.opValid = v; t.opCode = oc; t.operand = od;
    t.busy = b; t.halted = hl; t.pc = p;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rstN = 1'b0;
    run  = 1'b0;
    hold = 1'b0;
    run2 = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic clearRom;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, " progAddr"}, 32'(progAddr), 32'd0);
    chk({tag, " pcOut"},    32'(pcOut),    32'd0);
    chk({tag, " opCode"},   32'(opCode),   32'hC);
    chk({tag, " operand"},  32'(operand),  32'd0);
    chk({tag, " opValid"},  32'(opValid),  32'd0);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " halted"},   32'(halted),   32'd0);
  endtask

  vec_t       tbl [19];
  logic [3:0] mpc;
  logic [7:0] ins;
  logic [3:0] exOp, exOd;
  logic       sawAddr1, allBusy, done;
  int         opvCount, nHold;

  initial begin
    clearRom();
    doReset();
    rstN = 1'b0;
    #2;
    chkResetOutputs("reset");
    chk("reset progAddr2", 32'(progAddr2), 32'd0);
    rstN = 1'b1;
    tick();
    tick();
    chk("idle no run busy", 32'(busy), 32'd0);
    chk("idle no run opValid", 32'(opValid), 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
    // ---------------- single-step build ----------------
    clearRom();
    rom[0] = 8'h21; rom[1] = 8'h32;
    doReset();
    run = 1'b1;
    opvCount = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (opValid) opvCount++;
      if (c >= 5) begin
        chk("step wait busy", 32'(busy), 32'd0);
        chk("step wait pc", 32'(pcOut), 32'd1);
      end
    end
    chk("step first instr issues", 32'(opvCount), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step fetch busy", 32'(busy), 32'd1);
    opvCount = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (opValid) begin
        opvCount++;
        chk("step second opCode", 32'(opCode), 32'h3);
      end
    end
    chk("one opValid per step", 32'(opvCount), 32'd1);
`else
    // ---------------- linear program, table driven ----------------
    clearRom();
    rom[0] = 8'h21; rom[1] = 8'h32; rom[2] = 8'h00; rom[3] = 8'hF0;
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'd0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'd0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 4'h2, 4'h1, 1'b1, 1'b0, 4'd0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 4'h2, 4'h1, 1'b1, 1'b0, 4'd0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'd1);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'd1);
    tbl[6]  = mk(1'b1, 1'b0, 1'b1, 4'h3, 4'h2, 1'b1, 1'b0, 4'd1);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 4'h3, 4'h2, 1'b1, 1'b0, 4'd1);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'd2);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'd2);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 4'd2);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'd2);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'd3);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 1'b1, 1'b0, 4'd3);
    tbl[14] = mk(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 4'd3);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 1'b0, 1'b1, 4'd3);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 4'hC, 4'h0, 1'b0, 1'b1, 4'd3);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 1'b0, 1'b0, 4'd4);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 1'b0, 1'b0, 4'd4);
    doReset();
    for (int i = 0; i < 19; i++) begin
      run  = tbl[i].run;
      hold = tbl[i].hold;
      tick();
      chk($sformatf("lin[%0d] opValid", i),  32'(opValid),  32'(tbl[i].opValid));
      chk($sformatf("lin[%0d] opCode", i),   32'(opCode),   32'(tbl[i].opCode));
      chk($sformatf("lin[%0d] operand", i),  32'(operand),  32'(tbl[i].operand));
      chk($sformatf("lin[%0d] busy", i),     32'(busy),     32'(tbl[i].busy));
      chk($sformatf("lin[%0d] halted", i),   32'(halted),   32'(tbl[i].halted));
      chk($sformatf("lin[%0d] pcOut", i),    32'(pcOut),    32'(tbl[i].pc));
      chk($sformatf("lin[%0d] progAddr", i), 32'(progAddr), 32'(tbl[i].pc));
    end

    // ---------------- jump ----------------
    clearRom();
    rom[0] = 8'hB5; rom[1] = 8'h11; rom[5] = 8'hF0;
    doReset();
    run = 1'b1;
    sawAddr1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (busy && progAddr == 4'd1) sawAddr1 = 1'b1;
      if (c == 3) begin
        chk("jmp issue opCode", 32'(opCode), 32'hB);
        chk("jmp issue operand", 32'(operand), 32'h5);
      end
      if (c == 5) begin
        chk("jmp second fetch addr", 32'(progAddr), 32'd5);
        chk("jmp second fetch busy", 32'(busy), 32'd1);
      end
      if (c == 7) chk("jmp target opCode", 32'(opCode), 32'hF);
      if (c == 8) begin
        chk("jmp halted", 32'(halted), 32'd1);
        chk("jmp halted pc", 32'(pcOut), 32'd5);
      end
    end
    chk("jmp no fetch of addr 1", 32'(sawAddr1), 32'd0);
    run = 1'b0;
    tick();
    chk("halt exit pc+1", 32'(pcOut), 32'd6);
    chk("halt exit halted", 32'(halted), 32'd0);

    // ---------------- wrap (PC_W=2 instance) ----------------
    doReset();
    run2 = 1'b1;
    allBusy = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (!busy2) allBusy = 1'b0;
      if ((c - 1) % 4 == 0)
        chk($sformatf("wrap fetch %0d addr", (c - 1) / 4), 32'(progAddr2), 32'(((c - 1) / 4) % 4));
    end
    chk("wrap no stall", 32'(allBusy), 32'd1);
    run2 = 1'b0;

    // ---------------- hold ----------------
    clearRom();
    rom[0] = 8'h91; rom[1] = 8'hF0;
    doReset();
    run = 1'b1;
    hold = 1'b1;
    opvCount = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (opValid) opvCount++;
      if (c >= 3) begin
        chk($sformatf("hold c%0d opCode", c), 32'(opCode), 32'h9);
        chk($sformatf("hold c%0d operand", c), 32'(operand), 32'h1);
        chk($sformatf("hold c%0d pc", c), 32'(pcOut), 32'd0);
      end
    end
    hold = 1'b0;
    tick();
    if (opValid) opvCount++;
    chk("hold release pc", 32'(pcOut), 32'd1);
    chk("hold release opCode", 32'(opCode), 32'hC);
    chk("hold single opValid", 32'(opvCount), 32'd1);

    // ---------------- run drop during DECODE ----------------
    clearRom();
    rom[0] = 8'h21;
    doReset();
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    chk("rundrop issue opValid", 32'(opValid), 32'd1);
    chk("rundrop issue opCode", 32'(opCode), 32'h2);
    tick();
    chk("rundrop exec busy", 32'(busy), 32'd1);
    tick();
    chk("rundrop idle busy", 32'(busy), 32'd0);
    chk("rundrop idle pc", 32'(pcOut), 32'd1);
    tick();
    chk("rundrop stays idle", 32'(busy), 32'd0);

    // ---------------- async reset during EXEC ----------------
    doReset();
    run = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    chk("pre-reset exec opCode", 32'(opCode), 32'h2);
    #2;
    rstN = 1'b0;
    #1;
    chkResetOutputs("async reset");
    run = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    chk("after reset pc", 32'(pcOut), 32'd0);
    chk("after reset idle", 32'(busy), 32'd0);

    // ---------------- randomized programs vs. reference model ----------------
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) rom[i][7:4] = 4'hB;
      end
      doReset();
      mpc  = 4'd0;
      done = 1'b0;
      run  = 1'b1;
      tick();
      hold = 1'($urandom);
      tick();
      hold = 1'($urandom);
      tick();
      for (int k = 0; k < 25 && !done; k++) begin
        ins  = rom[mpc];
        exOp = ins[7:4];
        exOd = ins[3:0];
        chk($sformatf("rnd p%0d k%0d opValid", p, k), 32'(opValid), 32'd1);
        chk($sformatf("rnd p%0d k%0d opCode", p, k), 32'(opCode), 32'(exOp));
        chk($sformatf("rnd p%0d k%0d operand", p, k), 32'(operand), 32'(exOd));
        chk($sformatf("rnd p%0d k%0d pc", p, k), 32'(pcOut), 32'(mpc));
        if (exOp == 4'hF) begin
          tick();
          chk($sformatf("rnd p%0d halted", p), 32'(halted), 32'd1);
          chk($sformatf("rnd p%0d halt pc", p), 32'(pcOut), 32'(mpc));
          run = 1'b0;
          tick();
          chk($sformatf("rnd p%0d restart pc", p), 32'(pcOut), 32'((int'(mpc) + 1) % 16));
          done = 1'b1;
        end else begin
          hold = 1'($urandom);
          tick();
          nHold = $urandom_range(0, 3);
          for (int h = 0; h < nHold; h++) begin
            hold = 1'b1;
            tick();
            chk($sformatf("rnd p%0d k%0d held", p, k),
                32'({opValid, opCode, pcOut}), 32'({1'b0, exOp, mpc}));
          end
          hold = 1'b0;
          tick();
          if (exOp == 4'hB) mpc = exOd;
          else mpc = 4'((int'(mpc) + 1) % 16);
          chk($sformatf("rnd p%0d k%0d next pc", p, k), 32'(pcOut), 32'(mpc));
          chk($sformatf("rnd p%0d k%0d fetch opCode", p, k), 32'(opCode), 32'hC);
          hold = 1'($urandom);
          tick();
          hold = 1'($urandom);
          tick();
        end
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
